lut_loader: RTL and testbench
=============================

# lut_loader

Write-side loader for the 256 x 16 activation lookup memory read by the neuron datapath. It accepts a byte stream over a valid/ready handshake and pairs bytes into 16-bit words, low byte first. It writes each word to sequential memory addresses, starting at 0, and signals completion once DEPTH words are written. It sits between the host/config byte interface and the memory's write port; the neuron side keeps read-only access through the address/data port.

## Interface
- ADDR_W, 8, memory address width
- DATA_W, 16, memory word width (fixed at 2 bytes)
- DEPTH, 256, words per load; 1 <= DEPTH <= 2**ADDR_W
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE
- abort  input  1  synchronous cancel; honoured in any non-IDLE state
- in_valid  input  1  in_byte is valid
- in_ready  output  1  loader accepts a byte this cycle
- in_byte  input  8  stream byte
- wr_en  output  1  memory write strobe, one cycle per word
- wr_addr  output  ADDR_W  memory write address
- wr_data  output  DATA_W  memory write data, {hi_byte, lo_byte}
- busy  output  1  load in progress
- done  output  1  one-cycle pulse after the last word is written

## Operation
- States are IDLE, LO, HI, WRITE and DONE.
- **IDLE:** in_ready=0, busy=0.
  - start=1 goes to LO and clears the address counter to 0.
- **LO:** in_ready=1, busy=1.
  - A handshake (in_valid & in_ready) captures in_byte as the low byte and goes to HI.
  - No handshake: stay in LO.
- **HI:** in_ready=1, busy=1.
  - A handshake captures the high byte and goes to WRITE.
- **WRITE:** in_ready=0, busy=1, wr_en=1 for exactly this cycle, with wr_addr = counter and wr_data = {hi, lo}.
  - If counter == DEPTH-1, go to DONE.
  - Otherwise increment the counter and go to LO.
- **DONE:** done=1, busy=0, in_ready=0; next state is IDLE.
- **abort:** abort=1 in LO, HI or WRITE goes to IDLE with no done pulse.
  - In WRITE, abort suppresses wr_en that cycle.
  - Partial contents already written stay in memory.
  - abort in IDLE or DONE has no effect; DONE still pulses done.
- **start while busy:** ignored; neither the counter nor the state changes.
- **Simultaneous start and abort in IDLE:** start wins, because abort is ignored in IDLE.
- **Counter:** ADDR_W bits and never wraps. The terminal compare against DEPTH-1 ends the load before any wrap. With DEPTH = 2**ADDR_W the last address is all-ones.
- **Byte order:** fixed low-then-high. There is no resynchronisation other than abort or rst.

## Timing
- **Reset (rst=1, asynchronous):** state=IDLE, counter=0, and all outputs are 0 (in_ready, wr_en, wr_addr, wr_data, busy, done).
- **Reset mid-load:** immediate return to IDLE with no done pulse and no further writes.
- **Output sources:**
  - in_ready, busy and done decode combinationally from the state register only; they never depend on in_valid.
  - wr_addr and wr_data are driven from registers; wr_en is high only in WRITE.
- **Latency:** a high-byte handshake on edge N puts wr_en high in the cycle after N. LO is re-entered on edge N+1, so the earliest next low byte is taken on edge N+2.
- **Throughput:** at most one word per 3 cycles.
- **Minimum load time:** 3*DEPTH cycles from start to DONE, plus 1 cycle for DONE.
- **Stalls:** in_valid may drop at any cycle; the loader waits indefinitely in LO or HI.
- **Output hold:** wr_addr and wr_data hold their last values outside WRITE.

## Structure
- Shared package `ann_mem_pkg` holds:
  - the state enum (IDLE, LO, HI, WRITE, DONE) and its 3-bit encoding;
  - the LUT constants LUT_ADDR_W=8, LUT_DATA_W=16, LUT_DEPTH=256, which the memory uses as well.
- Single module; no sub-module is warranted.
- Contents: one FSM, one address counter, and an 8-bit low-byte register plus a 16-bit write-data register.

## Test plan
- **Full ramp load.** Start, then stream word k = 16'h0100+k for k=0..255, sent low byte first with in_valid held high.
  - Expect 256 wr_en pulses with wr_addr=k and wr_data=16'h0100+k.
  - Expect done exactly 769 cycles after start, then busy=0.
  - Read back through the memory port: addr 8'h2F returns 16'h012F.
- **Backpressure gaps.** in_valid toggles pseudo-randomly with DEPTH=4, data 16'hBEEF, 16'h1234, 16'h0000, 16'hFFFF.
  - Writes land at addr 0..3 with exactly those values; no extra or duplicated write.
- **Start while busy.** A second start pulse is applied in HI after word 1.
  - The counter is not reset; addresses continue 1, 2, ...; only one done pulse.
- **Abort mid-load.** Abort is asserted in WRITE for word 5.
  - No wr_en for addr 5; state returns to IDLE; done stays 0.
  - A new start writes from addr 0.
- **Async reset mid-load.** rst is asserted between clock edges while in HI.
  - All outputs read 0 immediately.
  - After release, the state is IDLE and in_ready=0 until start.
- **Boundary DEPTH=1.** Start, then bytes 8'h34, 8'h12.
  - Expect a single write of 16'h1234 at addr 0, done on the next cycle, and the counter never increments.

Source files
------------

// File: rtl/ann_mem_pkg.sv
// Shared definitions for the activation LUT memory and its write-side loader.
// The memory and the loader both size themselves from these constants.
package ann_mem_pkg;

  localparam int LUT_ADDR_W = 8;
  localparam int LUT_DATA_W = 16;
  localparam int LUT_DEPTH  = 256;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LO    = 3'd1,
    ST_HI    = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } lut_state_e;

endpackage

// File: rtl/lut_loader.sv
// Byte-stream loader for the activation LUT: pairs bytes low-first into words
// and writes them to sequential addresses 0..DEPTH-1, then pulses done.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; no byte acceptance
// ST_LO    | accepting the low byte of the current word
// ST_HI    | accepting the high byte of the current word
// ST_WRITE | wr_en asserted for the assembled word at the current address
// ST_DONE  | one-cycle done pulse after the last word, then back to idle
module lut_loader
  import ann_mem_pkg::*;
#(
  parameter int ADDR_W = LUT_ADDR_W,
  parameter int DATA_W = LUT_DATA_W,
  parameter int DEPTH  = LUT_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_byte,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done
);

  // Terminal address: the load ends here, so the counter never wraps.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  lut_state_e        state, state_n;
  logic [ADDR_W-1:0] cnt;
  logic [7:0]        lo_q;
  logic [DATA_W-1:0] data_q;
  logic              cnt_clr, cnt_inc, lo_ld, hi_ld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      lo_q   <= '0;
      data_q <= '0;
    end else begin
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + ADDR_W'(1);
      if (lo_ld) lo_q <= in_byte;
      if (hi_ld) data_q <= DATA_W'({in_byte, lo_q});
    end
  end

  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    wr_en    = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    lo_ld    = 1'b0;
    hi_ld    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_LO;
          cnt_clr = 1'b1;
        end
      end
      ST_LO: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (abort) state_n = ST_IDLE;
        else if (in_valid) begin
          lo_ld   = 1'b1;
          state_n = ST_HI;
        end
      end
      ST_HI: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (abort) state_n = ST_IDLE;
        else if (in_valid) begin
          hi_ld   = 1'b1;
          state_n = ST_WRITE;
        end
      end
      ST_WRITE: begin
        busy = 1'b1;
        // Abort wins over the write so a cancelled load leaves no half-step.
        if (abort) state_n = ST_IDLE;
        else begin
          wr_en = 1'b1;
          if (cnt == LAST_ADDR) state_n = ST_DONE;
          else begin
            cnt_inc = 1'b1;
            state_n = ST_LO;
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign wr_addr = cnt;
  assign wr_data = data_q;

endmodule

// File: tb/tb_lut_loader.sv
// Self-checking bench for lut_loader: three instances (DEPTH 256, 4, 1) driven
// from a byte-stream model; every write is logged and compared with the model.
module tb_lut_loader;

  typedef struct packed {
    logic [1:0]  sel;
    logic [7:0]  a;
    logic [15:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        abort, in_valid;
  logic [7:0]  in_byte;
  logic [2:0]  start_v, in_ready_v, wr_en_v, busy_v, done_v;
  logic [7:0]  wr_addr_v [3];
  logic [15:0] wr_data_v [3];

  int          checks = 0;
  int          fails  = 0;
  wr_t         obs[$];
  wr_t         exp_q[$];
  logic [7:0]  tx[$];
  logic [15:0] words[$];
  int          done_cnt [3];
  logic [15:0] mem0 [256];

  always #5 clk = ~clk;

  lut_loader #(.ADDR_W(8), .DATA_W(16), .DEPTH(256)) u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort), .in_valid(in_valid),
    .in_ready(in_ready_v[0]), .in_byte(in_byte), .wr_en(wr_en_v[0]),
    .wr_addr(wr_addr_v[0]), .wr_data(wr_data_v[0]), .busy(busy_v[0]), .done(done_v[0]));

  lut_loader #(.ADDR_W(8), .DATA_W(16), .DEPTH(4)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort), .in_valid(in_valid),
    .in_ready(in_ready_v[1]), .in_byte(in_byte), .wr_en(wr_en_v[1]),
    .wr_addr(wr_addr_v[1]), .wr_data(wr_data_v[1]), .busy(busy_v[1]), .done(done_v[1]));

  lut_loader #(.ADDR_W(8), .DATA_W(16), .DEPTH(1)) u2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .abort(abort), .in_valid(in_valid),
    .in_ready(in_ready_v[2]), .in_byte(in_byte), .wr_en(wr_en_v[2]),
    .wr_addr(wr_addr_v[2]), .wr_data(wr_data_v[2]), .busy(busy_v[2]), .done(done_v[2]));

  // Write/done log, sampled mid-cycle while inputs are stable.
  always @(negedge clk) begin
    for (int s = 0; s < 3; s++) begin
      if (wr_en_v[s]) obs.push_back('{sel: 2'(s), a: wr_addr_v[s], d: wr_data_v[s]});
      if (done_v[s]) done_cnt[s]++;
    end
    if (wr_en_v[0]) mem0[wr_addr_v[0]] = wr_data_v[0];
  end

  // Model: the stream is words split low byte first; the first n words land
  // at addresses 0..n-1.
  task automatic build_stream();
    tx.delete();
    foreach (words[k]) begin
      tx.push_back(words[k][7:0]);
      tx.push_back(words[k][15:8]);
    end
  endtask

  task automatic build_expect(input int sel, input int n);
    exp_q.delete();
    for (int k = 0; k < n; k++) exp_q.push_back('{sel: 2'(sel), a: 8'(k), d: words[k]});
  endtask

  // Index of the first disagreement between logged writes of sel and exp_q, or -1.
  function automatic int first_diff(input int sel);
    wr_t got[$];
    foreach (obs[j]) if (obs[j].sel == 2'(sel)) got.push_back(obs[j]);
    for (int j = 0; j < got.size() && j < exp_q.size(); j++)
      if (got[j] !== exp_q[j]) return j;
    if (got.size() != exp_q.size()) return (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    return -1;
  endfunction

  function automatic int got_count(input int sel);
    int n = 0;
    foreach (obs[j]) if (obs[j].sel == 2'(sel)) n++;
    return n;
  endfunction

  // Streams tx into instance sel; cyc is the cycle (start cycle = 0) where done is seen.
  task automatic run_load(input int sel, input int pct, input int abort_at,
                          input int restart_at, input int budget, output int cyc);
    int i = 0;
    bit hs = 0, restarted = 0, aborted = 0;
    obs.delete();
    done_cnt = '{default: 0};
    cyc = 0;
    @(posedge clk); #1;
    start_v[sel] = 1'b1;
    in_valid = 1'b0;
    abort = 1'b0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      start_v = '0;
      abort = 1'b0;
      if (hs) i++;
      hs = 0;
      if (aborted || done_v[sel]) break;
      if (cyc > budget) begin
        checks++; fails++;
        $display("FAIL load_timeout sel=%0d: done not seen after %0d cycles, bytes taken %0d", sel, cyc, i);
        break;
      end
      if (abort_at >= 0 && i == abort_at) begin
        abort = 1'b1;
        aborted = 1;
        in_valid = 1'b0;
      end else begin
        if (restart_at >= 0 && i == restart_at && !restarted) begin
          start_v[sel] = 1'b1;
          restarted = 1;
        end
        in_valid = (i < tx.size()) && ($urandom_range(99) < pct);
        in_byte = in_valid ? tx[i] : 8'($urandom);
        hs = in_valid && in_ready_v[sel];
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_v = '0; abort = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
    #12;
    checks++; if (in_ready_v[0] !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b want 0", in_ready_v[0]); end
    checks++; if (wr_en_v[0] !== 1'b0) begin fails++; $display("FAIL reset_wr_en: got %b want 0", wr_en_v[0]); end
    checks++; if (wr_addr_v[0] !== 8'h00) begin fails++; $display("FAIL reset_wr_addr: got %h want 00", wr_addr_v[0]); end
    checks++; if (wr_data_v[0] !== 16'h0000) begin fails++; $display("FAIL reset_wr_data: got %h want 0000", wr_data_v[0]); end
    checks++; if (busy_v !== 3'b000) begin fails++; $display("FAIL reset_busy: got %b want 000", busy_v); end
    checks++; if (done_v !== 3'b000) begin fails++; $display("FAIL reset_done: got %b want 000", done_v); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_full_ramp();
    int cyc, d;
    words.delete();
    for (int k = 0; k < 256; k++) words.push_back(16'h0100 + 16'(k));
    build_stream();
    build_expect(0, 256);
    run_load(0, 100, -1, -1, 2000, cyc);
    d = first_diff(0);
    checks++; if (d != -1) begin fails++; $display("FAIL ramp_writes: diff at entry %0d, got %0d writes want 256", d, got_count(0)); end
    checks++; if (cyc != 769) begin fails++; $display("FAIL ramp_done_cycle: got %0d want 769", cyc); end
    checks++; if (done_cnt[0] != 1) begin fails++; $display("FAIL ramp_done_count: got %0d want 1", done_cnt[0]); end
    checks++; if (busy_v[0] !== 1'b0) begin fails++; $display("FAIL ramp_busy_after: got %b want 0", busy_v[0]); end
    checks++; if (mem0[8'h2F] !== 16'h012F) begin fails++; $display("FAIL ramp_readback_2f: got %h want 012f", mem0[8'h2F]); end
  endtask

  task automatic test_backpressure();
    int cyc, d;
    words.delete();
    words.push_back(16'hBEEF); words.push_back(16'h1234);
    words.push_back(16'h0000); words.push_back(16'hFFFF);
    build_stream();
    build_expect(1, 4);
    run_load(1, 50, -1, -1, 500, cyc);
    d = first_diff(1);
    checks++; if (d != -1) begin fails++; $display("FAIL gaps_writes: diff at entry %0d, got %0d writes want 4", d, got_count(1)); end
    checks++; if (done_cnt[1] != 1) begin fails++; $display("FAIL gaps_done_count: got %0d want 1", done_cnt[1]); end
    checks++; if (cyc < 13) begin fails++; $display("FAIL gaps_min_time: got %0d cycles want >= 13", cyc); end
    for (int r = 0; r < 3; r++) begin
      words.delete();
      for (int k = 0; k < 4; k++) words.push_back(16'($urandom));
      build_stream();
      build_expect(1, 4);
      run_load(1, $urandom_range(90, 30), -1, -1, 500, cyc);
      d = first_diff(1);
      checks++; if (d != -1) begin fails++; $display("FAIL random_writes run %0d: diff at entry %0d, got %0d writes want 4", r, d, got_count(1)); end
      checks++; if (done_cnt[1] != 1) begin fails++; $display("FAIL random_done_count run %0d: got %0d want 1", r, done_cnt[1]); end
    end
  endtask

  task automatic test_start_while_busy();
    int cyc, d;
    words.delete();
    for (int k = 0; k < 256; k++) words.push_back(16'($urandom));
    build_stream();
    build_expect(0, 256);
    run_load(0, 100, -1, 3, 2000, cyc);
    d = first_diff(0);
    checks++; if (d != -1) begin fails++; $display("FAIL restart_writes: diff at entry %0d, got %0d writes want 256", d, got_count(0)); end
    checks++; if (done_cnt[0] != 1) begin fails++; $display("FAIL restart_done_count: got %0d want 1", done_cnt[0]); end
    checks++; if (cyc != 769) begin fails++; $display("FAIL restart_done_cycle: got %0d want 769", cyc); end
  endtask

  task automatic test_abort();
    int cyc, d;
    words.delete();
    for (int k = 0; k < 256; k++) words.push_back(16'($urandom));
    build_stream();
    build_expect(0, 5);
    run_load(0, 100, 12, -1, 2000, cyc);
    d = first_diff(0);
    checks++; if (d != -1) begin fails++; $display("FAIL abort_writes: diff at entry %0d, got %0d writes want 5", d, got_count(0)); end
    checks++; if (done_cnt[0] != 0) begin fails++; $display("FAIL abort_done_count: got %0d want 0", done_cnt[0]); end
    checks++; if (busy_v[0] !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b want 0", busy_v[0]); end
    checks++; if (in_ready_v[0] !== 1'b0) begin fails++; $display("FAIL abort_in_ready: got %b want 0", in_ready_v[0]); end
    words.delete();
    words.push_back(16'hA55A); words.push_back(16'h0F0F);
    build_stream();
    build_expect(0, 1);
    run_load(0, 100, 4, -1, 2000, cyc);
    d = first_diff(0);
    checks++; if (d != -1) begin fails++; $display("FAIL abort_restart_writes: diff at entry %0d, got %0d writes want 1 at addr 0", d, got_count(0)); end
  endtask

  task automatic test_async_reset();
    int n0;
    obs.delete();
    done_cnt = '{default: 0};
    @(posedge clk); #1 start_v[0] = 1'b1;
    @(posedge clk); #1 start_v[0] = 1'b0; in_valid = 1'b1; in_byte = 8'h77;
    @(posedge clk); #1 in_valid = 1'b0;
    checks++; if (busy_v[0] !== 1'b1 || in_ready_v[0] !== 1'b1) begin
      fails++; $display("FAIL arst_pre_state: busy %b in_ready %b want 1 1", busy_v[0], in_ready_v[0]);
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (in_ready_v[0] !== 1'b0 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || wr_en_v[0] !== 1'b0) begin
      fails++; $display("FAIL arst_ctrl: in_ready %b busy %b done %b wr_en %b want 0 0 0 0", in_ready_v[0], busy_v[0], done_v[0], wr_en_v[0]);
    end
    checks++; if (wr_addr_v[0] !== 8'h00 || wr_data_v[0] !== 16'h0000) begin
      fails++; $display("FAIL arst_data: wr_addr %h wr_data %h want 00 0000", wr_addr_v[0], wr_data_v[0]);
    end
    @(posedge clk); #1 rst = 1'b0; in_valid = 1'b1; in_byte = 8'h55;
    n0 = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (in_ready_v[0] !== 1'b0 || busy_v[0] !== 1'b0) n0++;
    end
    in_valid = 1'b0;
    checks++; if (n0 != 0) begin fails++; $display("FAIL arst_idle_after: %0d cycles with in_ready/busy high, want 0", n0); end
    checks++; if (got_count(0) != 0 || done_cnt[0] != 0) begin
      fails++; $display("FAIL arst_no_activity: writes %0d done %0d want 0 0", got_count(0), done_cnt[0]);
    end
  endtask

  task automatic test_depth1();
    int cyc, d;
    words.delete();
    words.push_back(16'h1234);
    build_stream();
    build_expect(2, 1);
    run_load(2, 100, -1, -1, 100, cyc);
    d = first_diff(2);
    checks++; if (d != -1) begin fails++; $display("FAIL depth1_writes: diff at entry %0d, got %0d writes want 1", d, got_count(2)); end
    checks++; if (cyc != 4) begin fails++; $display("FAIL depth1_done_cycle: got %0d want 4", cyc); end
    checks++; if (wr_addr_v[2] !== 8'h00) begin fails++; $display("FAIL depth1_counter: got %h want 00", wr_addr_v[2]); end
    checks++; if (done_cnt[2] != 1) begin fails++; $display("FAIL depth1_done_count: got %0d want 1", done_cnt[2]); end
  endtask

  initial begin
    test_reset();
    test_full_ramp();
    test_backpressure();
    test_start_while_busy();
    test_abort();
    test_async_reset();
    test_depth1();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
